alu_wb_stage: RTL

//  Writeback stage directly downstream of the combinational ALU. Captures each valid ALU result with its flags and destination register into a small FIFO.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_wb_stage_fifo.sv | 77 +++++++
 rtl/alu_wb_stage.sv | 92 +++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_pkg : shared opcode, flag and writeback-entry types for the ALU path  |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
package alu_pkg;

  localparam int c_XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_SRA  = 4'h7,
    OP_SLT  = 4'h8,
    OP_SLTU = 4'h9,
    OP_PASS = 4'hA
  } alu_op_e;

  typedef struct packed {
    logic cmp;
    logic neg;
    logic ovf;
    logic carry;
    logic zero;
  } alu_flags_t;

  typedef struct packed {
    logic [c_XLEN-1:0] data;
    logic [4:0]        rd;
    alu_op_e           op;
    alu_flags_t        flags;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/alu_wb_stage_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_wb_fifo : valid/ready FIFO of wb_entry_t with flush; head is held     |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
module alu_wb_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      i_flush,
  input  logic      i_push,
  output logic      o_ready,
  input  wb_entry_t i_entry,
  output logic      o_valid,
  input  logic      i_pop,
  output wb_entry_t o_entry
);

  localparam int               c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL  = (c_PTR_W + 1)'(DEPTH);

  wb_entry_t          r_mem [DEPTH];
  wb_entry_t          r_last;
  logic [c_PTR_W-1:0] r_wptr;
  logic [c_PTR_W-1:0] r_rptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_push;
  logic               w_pop;

  assign o_ready = (r_count != c_FULL);
  assign o_valid = (r_count != '0);
  assign w_push  = i_push & o_ready & ~i_flush;
  assign w_pop   = i_pop & o_valid;
  // While empty the head port replays the last entry shown, not stale storage.
  assign o_entry = o_valid ? r_mem[r_rptr] : r_last;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_last  <= '0;
    end else begin
      if (o_valid) begin
        r_last <= r_mem[r_rptr];
      end
      if (i_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        if (w_push && !w_pop) begin
          r_count <= r_count + 1'b1;
        end else if (w_pop && !w_push) begin
          r_count <= r_count - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_wb_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | alu_wb_stage : ALU writeback queue with commit flags, sticky bits, count  |
// | Rev 1.0 : initial release                                                 |
// +---------------------------------------------------------------------------+
module alu_wb_stage
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_result,
  input  logic [4:0]       i_in_flags,
  input  logic [3:0]       i_in_op,
  input  logic [4:0]       i_in_rd,
  input  logic             i_flush,
  output logic             o_wb_valid,
  input  logic             i_wb_ready,
  output logic [WIDTH-1:0] o_wb_data,
  output logic [4:0]       o_wb_rd,
  output logic [4:0]       o_flags_q,
  output logic [1:0]       o_sticky_q,
  input  logic             i_sticky_clr,
  output logic [CNT_W-1:0] o_commit_cnt,
  output logic             o_busy,
  output logic [7:0]       o_dbg_status
);

  wb_entry_t        w_in_entry;
  wb_entry_t        w_head;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  alu_flags_t       r_flags;
  logic [1:0]       r_sticky;
  logic [CNT_W-1:0] r_cnt;

  assign w_drop = DROP_X0 && (i_in_rd == 5'd0);
  assign w_push = i_in_valid & ~w_drop & ~i_flush;
  assign w_pop  = o_wb_valid & i_wb_ready;

  assign w_in_entry.data  = i_in_result;
  assign w_in_entry.rd    = i_in_rd;
  assign w_in_entry.op    = alu_op_e'(i_in_op);
  assign w_in_entry.flags = i_in_flags;

  alu_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (i_flush),
    .i_push  (w_push),
    .o_ready (o_in_ready),
    .i_entry (w_in_entry),
    .o_valid (o_wb_valid),
    .i_pop   (i_wb_ready),
    .o_entry (w_head)
  );

  assign o_wb_data    = w_head.data;
  assign o_wb_rd      = w_head.rd;
  assign o_dbg_status = {4'h0, w_head.op};
  assign o_busy       = o_wb_valid;
  assign o_flags_q    = r_flags;
  assign o_sticky_q   = r_sticky;
  assign o_commit_cnt = r_cnt;

  // A commit in the same cycle as sticky_clr re-seeds the sticky bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags  <= '0;
      r_sticky <= '0;
      r_cnt    <= '0;
    end else if (w_pop) begin
      r_flags  <= w_head.flags;
      r_cnt    <= r_cnt + 1'b1;
      r_sticky <= (i_sticky_clr ? 2'b00 : r_sticky) |
                  {w_head.flags.ovf, w_head.flags.carry};
    end else if (i_sticky_clr) begin
      r_sticky <= '0;
    end
  end

endmodule
`default_nettype wire
